imm_decode_unit: RTL and testbench
==================================

IMM_DECODE_UNIT -- requirements
Module: imm_decode_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 2, output queue entries; legal values 1..4.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all queued entries.
REQ-006 SHALL have port in_valid, input, 1, instr is presented.
REQ-007 SHALL have port in_ready, output, 1, the unit accepts instr this cycle.
REQ-008 SHALL have port instr, input, 32, RV instruction word.
REQ-009 SHALL have port out_valid, output, 1, the head entry is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer takes the head entry.
REQ-011 SHALL have port imm, output, XLEN, decoded immediate of the head entry.
REQ-012 SHALL have port fmt, output, 3, format of the head entry: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=ILLEGAL.
REQ-013 SHALL have port illegal, output, 1, high when fmt==7.

Function
REQ-014 SHALL select the format from instr[6:0]: 0110111/0010111->U; 1101111->J; 1100111, 0000011, 0010011, 1110011->I; 0011011->I only when XLEN==64; 0100011->S; 1100011->B; 0110011->R; 0111011->R only when XLEN==64; all other opcodes->ILLEGAL.
REQ-015 SHALL override I with SHAMT for opcodes 0010011/0011011 when funct3 is 001 or 101.
REQ-016 SHALL form the I immediate as instr[31:20] sign-extended to XLEN.
REQ-017 SHALL form the S immediate as {instr[31:25],instr[11:7]} sign-extended to XLEN.
REQ-018 SHALL form the B immediate as {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-extended to XLEN.
REQ-019 SHALL form the U immediate as {instr[31:12],12'b0} sign-extended from bit 31 to XLEN.
REQ-020 SHALL form the J immediate as {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-extended to XLEN.
REQ-021 SHALL form the SHAMT immediate, zero-extended with funct7 bits excluded, as: instr[24:20] when XLEN==32 or opcode 0011011; instr[25:20] otherwise.
REQ-022 SHALL output imm=0 for R and ILLEGAL.
REQ-023 SHALL decode combinationally at input and push {imm, fmt} into a DEPTH-entry FIFO on in_valid && in_ready.
REQ-024 SHALL drive in_ready = (count < DEPTH) && !flush; a push is never accepted while full, even when a pop occurs in the same cycle.
REQ-025 SHALL pop the head on out_valid && out_ready; out_valid = (count != 0).
REQ-026 SHALL give one-cycle latency: an entry accepted at edge N is visible on imm/fmt with out_valid at N+1 when the queue was empty.
REQ-027 SHALL preserve order and update count by +1 on push-only, -1 on pop-only, and 0 on simultaneous push and pop.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL give flush priority over push and pop: at the edge, count and pointers become 0, and the pop is not counted.
REQ-030 SHALL drive imm=0 and fmt=0 whenever out_valid==0.

Reset
REQ-031 SHALL, while rst is high, asynchronously force count=0, both pointers=0, out_valid=0, imm=0, fmt=0, and illegal=0; in_ready SHALL be 1 after release.
REQ-032 SHALL discard any in-flight entries when rst asserts mid-stream; no stale entry reappears after release.

Verification
REQ-033 SHALL pass: XLEN=32, push 0xFE112E23 (sw) with out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFC, fmt=2.
REQ-034 SHALL pass: XLEN=64, push 0x800002B7 (lui) -> imm=0xFFFFFFFF80000000, fmt=4; push 0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF, fmt=1.
REQ-035 SHALL pass: XLEN=32, push 0x4050D093 (srai 5) -> imm=0x5, fmt=6; push 0x01F09093 (slli 31) -> imm=0x1F, fmt=6.
REQ-036 SHALL pass: push 0x0000007F -> fmt=7, illegal=1, imm=0.
REQ-037 SHALL pass: DEPTH=2, out_ready=0, offer 3 instructions -> in_ready=0 after the 2nd push, and the 3rd is held; then raise out_ready -> entries drain in order, and the 3rd is accepted once count<2.
REQ-038 SHALL pass: with 2 queued entries, assert flush together with in_valid -> next cycle out_valid=0 and count=0, and the offered instruction is not queued; repeat with rst asserted mid-cycle -> immediate out_valid=0.

Source files
------------

// File: rtl/imm_decode_unit.sv
// RISC-V immediate decoder feeding a small in-order output queue.
// Each accepted instruction is decoded on the way in and stored as {imm, fmt}.
module imm_decode_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R       = 3'd0;
  localparam logic [2:0] FMT_I       = 3'd1;
  localparam logic [2:0] FMT_S       = 3'd2;
  localparam logic [2:0] FMT_B       = 3'd3;
  localparam logic [2:0] FMT_U       = 3'd4;
  localparam logic [2:0] FMT_J       = 3'd5;
  localparam logic [2:0] FMT_SHAMT   = 3'd6;
  localparam logic [2:0] FMT_ILLEGAL = 3'd7;

  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [XLEN-1:0] dec_imm_s;
  logic [2:0]      dec_fmt_s;
  logic            is_shift_s;
  logic            push_s;
  logic            pop_s;

  logic [XLEN-1:0] mem_imm_q [DEPTH];
  logic [XLEN-1:0] mem_imm_d [DEPTH];
  logic [2:0]      mem_fmt_q [DEPTH];
  logic [2:0]      mem_fmt_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Classify the incoming opcode and build its immediate.
  always_comb begin
    is_shift_s = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);
    dec_fmt_s  = FMT_ILLEGAL;
    dec_imm_s  = {XLEN{1'b0}};
    case (instr[6:0])
      7'b0110111, 7'b0010111:            dec_fmt_s = FMT_U;
      7'b1101111:                        dec_fmt_s = FMT_J;
      7'b1100111, 7'b0000011, 7'b1110011: dec_fmt_s = FMT_I;
      7'b0010011:                        dec_fmt_s = is_shift_s ? FMT_SHAMT : FMT_I;
      7'b0011011: begin
        if (!RV64) begin
          dec_fmt_s = FMT_ILLEGAL;
        end else begin
          dec_fmt_s = is_shift_s ? FMT_SHAMT : FMT_I;
        end
      end
      7'b0100011:                        dec_fmt_s = FMT_S;
      7'b1100011:                        dec_fmt_s = FMT_B;
      7'b0110011:                        dec_fmt_s = FMT_R;
      7'b0111011:                        dec_fmt_s = RV64 ? FMT_R : FMT_ILLEGAL;
      default:                           dec_fmt_s = FMT_ILLEGAL;
    endcase

    case (dec_fmt_s)
      FMT_I: dec_imm_s = XLEN'($signed(instr[31:20]));
      FMT_S: dec_imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B: dec_imm_s = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U: dec_imm_s = XLEN'($signed({instr[31:12], 12'd0}));
      FMT_J: dec_imm_s = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_SHAMT: begin
        // RV32 shifts and the 32-bit W shifts only carry a 5-bit amount.
        if (!RV64 || (instr[6:0] == 7'b0011011)) begin
          dec_imm_s = XLEN'(instr[24:20]);
        end else begin
          dec_imm_s = XLEN'(instr[25:20]);
        end
      end
      default: dec_imm_s = {XLEN{1'b0}};
    endcase
  end

  assign in_ready  = (count_q < DEPTH_CNT) && !flush;
  assign out_valid = (count_q != {CW{1'b0}});
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Queue next-state: flush wins over any push or pop in the same cycle.
  always_comb begin
    mem_imm_d = mem_imm_q;
    mem_fmt_d = mem_fmt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if (flush) begin
      wptr_d  = {PW{1'b0}};
      rptr_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_imm_d[wptr_q] = dec_imm_s;
        mem_fmt_d[wptr_q] = dec_fmt_s;
        wptr_d = (wptr_q == LAST_PTR) ? {PW{1'b0}} : wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = (rptr_q == LAST_PTR) ? {PW{1'b0}} : rptr_q + PW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm_q[i] <= {XLEN{1'b0}};
        mem_fmt_q[i] <= 3'd0;
      end
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      mem_imm_q <= mem_imm_d;
      mem_fmt_q <= mem_fmt_d;
    end
  end

  assign imm     = out_valid ? mem_imm_q[rptr_q] : {XLEN{1'b0}};
  assign fmt     = out_valid ? mem_fmt_q[rptr_q] : 3'd0;
  assign illegal = out_valid && (mem_fmt_q[rptr_q] == FMT_ILLEGAL);

endmodule

// File: tb/tb_imm_decode_unit.sv
// Bench for imm_decode_unit: RV32 and RV64 instances driven in lockstep,
// checked against a queue-of-instructions model with an arithmetic decoder.
module tb_imm_decode_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q[$];

  logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h73,
                           7'h13, 7'h1B, 7'h23, 7'h63, 7'h33, 7'h3B};

  imm_decode_unit #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32),
    .fmt(fmt32), .illegal(illegal32)
  );

  imm_decode_unit #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64),
    .fmt(fmt64), .illegal(illegal64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decoder written from the ISA encoding rules with plain arithmetic.
  function automatic void ref_decode(input bit x64, input logic [31:0] ins,
                                     output logic [63:0] v, output logic [2:0] f);
    longint s;
    logic [12:0] ub;
    logic [20:0] uj;
    bit sh;
    s  = longint'($signed(ins));
    sh = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    ub = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    uj = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    v = 64'd0;
    f = 3'd7;
    case (ins[6:0])
      7'h37, 7'h17: begin f = 3'd4; v = s & 64'hFFFF_FFFF_FFFF_F000; end
      7'h6F: begin f = 3'd5; v = {43'd0, uj} - (ins[31] ? 64'd2097152 : 64'd0); end
      7'h67, 7'h03, 7'h73: begin f = 3'd1; v = s >>> 20; end
      7'h13, 7'h1B: begin
        if (ins[6:0] == 7'h1B && !x64) begin
          f = 3'd7;
        end else if (sh) begin
          f = 3'd6;
          v = (!x64 || ins[6:0] == 7'h1B) ? 64'((ins >> 20) & 32'd31) : 64'((ins >> 20) & 32'd63);
        end else begin
          f = 3'd1;
          v = s >>> 20;
        end
      end
      7'h23: begin f = 3'd2; v = (s >>> 25) * 32 + longint'(ins[11:7]); end
      7'h63: begin f = 3'd3; v = {51'd0, ub} - (ins[31] ? 64'd8192 : 64'd0); end
      7'h33: f = 3'd0;
      7'h3B: f = x64 ? 3'd0 : 3'd7;
      default: f = 3'd7;
    endcase
    if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // One clock of stimulus: drive, compare against the model, advance model at the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic [63:0] e32, e64;
    logic [2:0]  f32, f64;
    logic        exp_rdy, exp_ov;
    in_valid = v; instr = ins; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (q.size() < 2) && !fl;
    exp_ov  = (q.size() != 0);
    e32 = 64'd0; e64 = 64'd0; f32 = 3'd0; f64 = 3'd0;
    if (exp_ov) begin
      ref_decode(1'b0, q[0], e32, f32);
      ref_decode(1'b1, q[0], e64, f64);
    end
    chk("in_ready32", in_ready32, exp_rdy);
    chk("in_ready64", in_ready64, exp_rdy);
    chk("out_valid32", out_valid32, exp_ov);
    chk("out_valid64", out_valid64, exp_ov);
    chk("imm32", imm32, e32);
    chk("imm64", imm64, e64);
    chk("fmt32", fmt32, f32);
    chk("fmt64", fmt64, f64);
    chk("illegal32", illegal32, exp_ov && f32 == 3'd7);
    chk("illegal64", illegal64, exp_ov && f64 == 3'd7);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (exp_ov && ordy) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(ins);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 13);
    if (k < 12) r[6:0] = ops[k];
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 32'd0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid32", out_valid32, 1'b0);
    chk("rst_out_valid64", out_valid64, 1'b0);
    chk("rst_imm32", imm32, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_fmt32", fmt32, 3'd0);
    chk("rst_illegal32", illegal32, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_in_ready32", in_ready32, 1'b1);
    chk("rel_in_ready64", in_ready64, 1'b1);

    // Known encodings with the consumer always ready.
    step(1'b1, 32'hFE112E23, 1'b1, 1'b0);
    chk("sw_valid32", out_valid32, 1'b1);
    chk("sw_imm32", imm32, 64'hFFFF_FFFC);
    chk("sw_fmt32", fmt32, 3'd2);
    step(1'b1, 32'h800002B7, 1'b1, 1'b0);
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_fmt64", fmt64, 3'd4);
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_fmt64", fmt64, 3'd1);
    step(1'b1, 32'h4050D093, 1'b1, 1'b0);
    chk("srai_imm32", imm32, 64'h5);
    chk("srai_fmt32", fmt32, 3'd6);
    step(1'b1, 32'h01F09093, 1'b1, 1'b0);
    chk("slli_imm32", imm32, 64'h1F);
    chk("slli_fmt32", fmt32, 3'd6);
    step(1'b1, 32'h0000007F, 1'b1, 1'b0);
    chk("ill_fmt32", fmt32, 3'd7);
    chk("ill_flag32", illegal32, 1'b1);
    chk("ill_imm32", imm32, 64'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure: third instruction waits until a slot frees.
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 1'b0, 1'b0);
    chk("full_in_ready32", in_ready32, 1'b0);
    step(1'b1, 32'h00300193, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 1'b1, 1'b0);
    step(1'b1, 32'h00300193, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with two queued entries and an offered instruction.
    step(1'b1, 32'h00400213, 1'b0, 1'b0);
    step(1'b1, 32'h00500293, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 1'b1, 1'b1);
    chk("flush_out_valid32", out_valid32, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Reset asserted mid-cycle with two entries queued.
    step(1'b1, 32'h00700393, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid32", out_valid32, 1'b0);
    chk("mid_rst_out_valid64", out_valid64, 1'b0);
    chk("mid_rst_imm64", imm64, 64'd0);
    chk("mid_rst_illegal32", illegal32, 1'b0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
